// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one sum bit per clock, LSB first.
// Defining SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the operation into a - b.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             bit_out,
   output logic             bit_valid
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_part;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_load;
   logic             w_last;
   logic             w_s;
   logic             w_co;
   logic [WIDTH:0]   w_part_ext;
   logic [WIDTH-1:0] w_part_nxt;
   logic [WIDTH-1:0] w_b_load;
   logic             w_c_load;

   // Subtraction is a + ~b + 1, so only the loaded B and carry change.
`ifdef SERIAL_ADDER_SUB_EN
   assign w_b_load = sub ? ~b : b;
   assign w_c_load = sub ? 1'b1 : cin;
`else
   assign w_b_load = b;
   assign w_c_load = cin;
`endif

   assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
   assign w_co       = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
   assign w_part_ext = {w_s, r_part};
   assign w_part_nxt = w_part_ext[WIDTH:1];
   assign w_last     = (r_cnt == LAST_BIT);

   // Next-state and start-acceptance decode.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_SHIFT;
            end
         end
         S_DONE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = S_SHIFT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_load      = 1'b0;
         end
      endcase
   end

   // State, operand shifters, counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= 1'b0;
         r_cnt   <= '0;
         r_part  <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_a   <= a;
            r_b   <= w_b_load;
            r_c   <= w_c_load;
            r_cnt <= '0;
         end else if (r_state == S_SHIFT) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_c    <= w_co;
            r_part <= w_part_nxt;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
               r_sum  <= w_part_nxt;
               r_cout <= w_co;
            end
         end
      end
   end

   // bit_out is gated so it reads 0 outside SHIFT, including during reset.
   assign busy      = (r_state == S_SHIFT);
   assign bit_valid = (r_state == S_SHIFT);
   assign done      = (r_state == S_DONE);
   assign bit_out   = (r_state == S_SHIFT) ? w_s : 1'b0;
   assign sum       = r_sum;
   assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4): vector table, scoreboard queue, corner sequences.
// Subtract vectors are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

   localparam int W = 4;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin   = 1'b0;
   logic         sub   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         bit_out;
   logic         bit_valid;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         c;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
   } res_t;

   res_t sb_q[$];
   res_t mon_r;
   vec_t vt[$];
   int   n_vec = 0;
   int   n_err = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
      .bit_out   (bit_out),
      .bit_valid (bit_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
         end else begin
            mon_r = sb_q.pop_front();
            chk("sb_sum", 32'(sum), 32'(mon_r.s));
            chk("sb_cout", 32'(cout), 32'(mon_r.c));
         end
      end
   end

   task automatic run_op(input vec_t v, input bit poke);
      @(negedge clk);
      chk("pre_busy", 32'(busy), 32'd0);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
      sb_q.push_back('{v.s, v.c});
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         start = (poke && k == 1);
         if (poke && k == 1) begin
            a = 4'b0001; b = 4'b0000; cin = 1'b0;
         end
         chk("shift_busy", 32'(busy), 32'd1);
         chk("shift_valid", 32'(bit_valid), 32'd1);
         chk("shift_done", 32'(done), 32'd0);
         chk("bit_out", 32'(bit_out), 32'(v.s[k]));
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_valid", 32'(bit_valid), 32'd0);
   endtask

   initial begin
      vec_t v;
      int   t;

      vt.push_back('{4'b0011, 4'b0101, 1'b0, 1'b0, 4'b1000, 1'b0});
      vt.push_back('{4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1});
      vt.push_back('{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1});
      vt.push_back('{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0});
      vt.push_back('{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0001, 1'b0});
      vt.push_back('{4'b1010, 4'b0101, 1'b1, 1'b0, 4'b0000, 1'b1});
      vt.push_back('{4'b1001, 4'b0110, 1'b0, 1'b0, 4'b1111, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
      vt.push_back('{4'b0101, 4'b0111, 1'b0, 1'b1, 4'b1110, 1'b0});
      vt.push_back('{4'b0111, 4'b0101, 1'b1, 1'b1, 4'b0010, 1'b1});
`endif

      // Reset state.
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_valid", 32'(bit_valid), 32'd0);
      chk("rst_bit", 32'(bit_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         run_op(vt[i], 1'b0);
      end

      // Start pulsed mid-operation must be ignored.
      run_op(vt[0], 1'b1);
      @(negedge clk);
      chk("poke_idle_busy", 32'(busy), 32'd0);
      chk("poke_idle_done", 32'(done), 32'd0);

      // Reset during SHIFT aborts with no done pulse and clears the old result.
      @(negedge clk);
      a = 4'b1010; b = 4'b0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_valid", 32'(bit_valid), 32'd0);
      chk("abort_bit", 32'(bit_out), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) begin
         @(negedge clk);
         chk("post_abort_busy", 32'(busy), 32'd0);
         chk("post_abort_done", 32'(done), 32'd0);
      end

      // Back-to-back with start held high: done every W+1 cycles.
      @(negedge clk);
      a = 4'b0011; b = 4'b0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
      sb_q.push_back('{4'b1000, 1'b0});
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         if (k == 0) begin
            a = 4'b1111; b = 4'b0001; cin = 1'b0;
         end
         chk("b2b1_busy", 32'(busy), 32'd1);
         chk("b2b1_done", 32'(done), 32'd0);
      end
      @(negedge clk);
      chk("b2b1_pulse", 32'(done), 32'd1);
      chk("b2b1_busy_low", 32'(busy), 32'd0);
      sb_q.push_back('{4'b0000, 1'b1});
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         chk("b2b2_busy", 32'(busy), 32'd1);
         chk("b2b2_bit", 32'(bit_out), 32'd0);
      end
      @(negedge clk);
      chk("b2b2_pulse", 32'(done), 32'd1);
      chk("b2b2_busy_low", 32'(busy), 32'd0);
      start = 1'b0;
      @(negedge clk);
      chk("b2b_idle_done", 32'(done), 32'd0);
      chk("b2b_idle_busy", 32'(busy), 32'd0);

      // Random additions checked against an integer model.
      for (int i = 0; i < 16; i++) begin
         v.a   = W'($urandom_range(0, 15));
         v.b   = W'($urandom_range(0, 15));
         v.cin = 1'($urandom_range(0, 1));
         v.sub = 1'b0;
         t     = int'(v.a) + int'(v.b) + int'(v.cin);
         v.s   = t[W-1:0];
         v.c   = t[W];
         run_op(v, 1'b0);
      end

      @(negedge clk);
      @(negedge clk);
      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_drain: got %0d pending results expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
